// File: rtl/vdff_reg_cells_pkg.sv
// Shared widths for the register-cell slice.
package vdff_reg_cells_pkg;

  localparam int unsigned FLAG_W = 1;
  localparam int unsigned DATA_W = 8;

endpackage

// File: rtl/vdff_reg_cells_if.sv
// Bundle of data/enable/state signals around the register cells.
// master drives next-state data and enables; slave returns registered state.
interface vdff_reg_cells_if;
  import vdff_reg_cells_pkg::*;

  logic [FLAG_W-1:0] d1;        // plain flag register input
  logic [FLAG_W-1:0] q1;        // plain flag register state
  logic              en8;       // load enable for the byte register
  logic [DATA_W-1:0] d8;        // byte register input
  logic [DATA_W-1:0] q8;        // byte register state
  logic              pulse;     // set pulse for the sticky flag
  logic [FLAG_W-1:0] sticky;    // sticky flag state
  logic              chain_en;  // shared enable of the two-stage chain
  logic [DATA_W-1:0] chain_in;  // chain input
  logic [DATA_W-1:0] stage1;    // chain first stage
  logic [DATA_W-1:0] stage2;    // chain second stage

  modport master (
    output d1, en8, d8, pulse, chain_en, chain_in,
    input  q1, q8, sticky, stage1, stage2
  );

  modport slave (
    input  d1, en8, d8, pulse, chain_en, chain_in,
    output q1, q8, sticky, stage1, stage2
  );

endinterface

// File: rtl/vdff_reg_cells_prims.sv
// Generic register primitives, instantiated positionally.
//   vDFF    (clk, rst, in, out)     : plain D register
//   vDFF_en (clk, rst, en, in, out) : D register with load enable
// Both reset synchronously to zero on rst=1; reset beats enable.

module vDFF #(
  parameter int unsigned n = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] in,
  output logic [n-1:0] out
);

  // Single clocked process; reset value of zero is relied on by OR-combining consumers.
  always_ff @(posedge clk) begin
    if (rst) out <= '0;
    else     out <= in;
  end

endmodule

module vDFF_en #(
  parameter int unsigned n = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [n-1:0] in,
  output logic [n-1:0] out
);

  // Hold when en=0; the hold path is the 2:1 mux implied by the missing else.
  always_ff @(posedge clk) begin
    if (rst)     out <= '0;
    else if (en) out <= in;
  end

endmodule

// File: rtl/vdff_reg_cells.sv
// Slice exercising the register primitives the way the pipeline uses them.
// Ports: clk, rst (sync, active-high), bus (slave side of vdff_reg_cells_if).
//   q1     : vDFF of d1
//   q8     : vDFF_en of d8 under en8
//   sticky : self-fed vDFF, set by pulse and held until rst
//   stage1/stage2 : two vDFF_en in series under chain_en
module vdff_reg_cells
  import vdff_reg_cells_pkg::*;
(
  input logic              clk,
  input logic              rst,
  vdff_reg_cells_if.slave  bus
);

  logic [FLAG_W-1:0] sticky_next_c;

  // Feedback through the register turns it into a set-only latch cleared by rst.
  assign sticky_next_c = bus.pulse | bus.sticky;

  vDFF    #(FLAG_W) u_flag   (clk, rst, bus.d1, bus.q1);
  vDFF_en #(DATA_W) u_byte   (clk, rst, bus.en8, bus.d8, bus.q8);
  vDFF    #(FLAG_W) u_sticky (clk, rst, sticky_next_c, bus.sticky);
  vDFF_en #(DATA_W) u_stage1 (clk, rst, bus.chain_en, bus.chain_in, bus.stage1);
  vDFF_en #(DATA_W) u_stage2 (clk, rst, bus.chain_en, bus.stage1, bus.stage2);

endmodule

// File: tb/tb_vdff_reg_cells.sv
module tb_vdff_reg_cells;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  vdff_reg_cells_if bus ();

  vdff_reg_cells dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference state: what each register should hold after the last edge.
  logic       m_q1;
  logic [7:0] m_q8;
  logic       m_sticky;
  logic [7:0] m_pipe [2];   // chain contents, index 0 = stage1

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_q1"},     64'(bus.q1),     64'(m_q1));
    check({tag, "_q8"},     64'(bus.q8),     64'(m_q8));
    check({tag, "_sticky"}, 64'(bus.sticky), 64'(m_sticky));
    check({tag, "_stage1"}, 64'(bus.stage1), 64'(m_pipe[0]));
    check({tag, "_stage2"}, 64'(bus.stage2), 64'(m_pipe[1]));
  endtask

  // Apply the register rules to the inputs that were present at the edge.
  task automatic model_edge();
    if (rst) begin
      m_q1 = 1'b0; m_q8 = 8'h00; m_sticky = 1'b0;
      m_pipe[0] = 8'h00; m_pipe[1] = 8'h00;
    end else begin
      m_q1 = bus.d1;
      if (bus.en8) m_q8 = bus.d8;
      if (bus.pulse) m_sticky = 1'b1;
      if (bus.chain_en) begin
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = bus.chain_in;
      end
    end
  endtask

  // One clock: advance, let outputs settle, update model, compare.
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    model_edge();
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    bus.d1 = 1'b0; bus.en8 = 1'b0; bus.d8 = 8'h00; bus.pulse = 1'b0;
    bus.chain_en = 1'b0; bus.chain_in = 8'h00;

    // Reset state
    step("reset");
    check("reset_q8_zero", 64'(bus.q8), 64'h0);

    // 1: plain flag register
    rst = 1'b0; bus.d1 = 1'b1;
    step("t1_set");
    check("t1_q1_one", 64'(bus.q1), 64'h1);
    bus.d1 = 1'b0;
    step("t1_clear");

    // 2: load, hold with en=0 for three edges, then load
    bus.en8 = 1'b1; bus.d8 = 8'hA5;
    step("t2_load");
    bus.en8 = 1'b0; bus.d8 = 8'h3C;
    for (int i = 0; i < 3; i++) step("t2_hold");
    check("t2_held_a5", 64'(bus.q8), 64'hA5);
    bus.en8 = 1'b1;
    step("t2_reload");
    check("t2_q8_3c", 64'(bus.q8), 64'h3C);

    // 3: reset beats enable, then data loads on the next edge
    bus.d8 = 8'hFF;
    step("t3_ff");
    rst = 1'b1; bus.d8 = 8'h55;
    step("t3_rst");
    check("t3_q8_zero", 64'(bus.q8), 64'h0);
    rst = 1'b0;
    step("t3_release");
    check("t3_q8_55", 64'(bus.q8), 64'h55);

    // 4: sticky flag holds after a single-cycle pulse until reset
    bus.pulse = 1'b1;
    step("t4_pulse");
    bus.pulse = 1'b0;
    for (int i = 0; i < 4; i++) step("t4_hold");
    check("t4_sticky_one", 64'(bus.sticky), 64'h1);
    rst = 1'b1;
    step("t4_rst");
    rst = 1'b0;

    // 5: mid-cycle rst and input toggles have no effect before the edge
    bus.d1 = 1'b1; bus.en8 = 1'b1; bus.d8 = 8'h9A;
    step("t5_prime");
    rst = 1'b1; bus.d1 = 1'b0; bus.d8 = 8'h11;
    #2; check_all("t5_mid1");
    bus.d1 = 1'b1; bus.d8 = 8'h22;
    #1; check_all("t5_mid2");
    step("t5_edge");
    check("t5_q1_zero", 64'(bus.q1), 64'h0);
    rst = 1'b0;

    // 6: two-stage chain, then hold
    bus.chain_en = 1'b1; bus.chain_in = 8'h12;
    step("t6_s1");
    check("t6_stage1_12", 64'(bus.stage1), 64'h12);
    bus.chain_in = 8'h00;
    step("t6_s2");
    check("t6_stage2_12", 64'(bus.stage2), 64'h12);
    bus.chain_en = 1'b0; bus.chain_in = 8'h77;
    step("t6_hold");
    step("t6_hold");

    // Randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      rst          = ($urandom_range(0, 15) == 0);
      bus.d1       = 1'($urandom);
      bus.en8      = 1'($urandom);
      bus.d8       = 8'($urandom);
      bus.pulse    = ($urandom_range(0, 7) == 0);
      bus.chain_en = 1'($urandom);
      bus.chain_in = 8'($urandom);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
